// File: rtl/mul_share_arbiter.sv
// ============================================================================
// Module   : mul_share_arbiter
// Purpose  : Round-robin time-sharing of one external combinational multiplier
//            between two valid/ready requesters, with a registered response.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 req0_valid,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  output logic                 req0_ready,
  output logic                 resp0_valid,
  output logic [2*WIDTH-1:0]   resp0_p,
  input  logic                 resp0_ready,

  input  logic                 req1_valid,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 req1_ready,
  output logic                 resp1_valid,
  output logic [2*WIDTH-1:0]   resp1_p,
  input  logic                 resp1_ready,

  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_p
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_op_a;
  logic [WIDTH-1:0]     r_op_b;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 r_owner;
  logic                 r_prio;

  logic                 w_grant_vld;
  logic                 w_grant_id;
  logic                 w_accept;
  logic                 w_capture;
  logic                 w_release;
  logic                 w_owner_ready;

  // On contention the favoured requester wins; otherwise whoever is asking.
  always_comb begin
    w_grant_vld = req0_valid | req1_valid;
    w_grant_id  = (req0_valid & req1_valid) ? r_prio : req1_valid;
  end

  assign w_owner_ready = r_owner ? resp1_ready : resp0_ready;

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    resp0_p     = '0;
    resp1_p     = '0;
    mul_a       = '0;
    mul_b       = '0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;

    case (r_state)
      IDLE: begin
        // Ready is gated by rst_n so every output is quiet while in reset.
        if (w_grant_vld && rst_n) begin
          req0_ready  = ~w_grant_id;
          req1_ready  = w_grant_id;
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end

      ISSUE: begin
        mul_a       = r_op_a;
        mul_b       = r_op_b;
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end

      RESP: begin
        if (r_owner) begin
          resp1_valid = 1'b1;
          resp1_p     = r_prod;
        end else begin
          resp0_valid = 1'b1;
          resp0_p     = r_prod;
        end
        if (w_owner_ready) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_prod  <= '0;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op_a  <= w_grant_id ? req1_a : req0_a;
        r_op_b  <= w_grant_id ? req1_b : req0_b;
        r_owner <= w_grant_id;
      end
      if (w_capture) begin
        r_prod <= mul_p;
      end
      if (w_release) begin
        r_prio <= ~r_owner;
      end
    end
  end

endmodule

`default_nettype wire
